// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: loads a program into the accumulator core's instruction memory,
// then clears the core and runs it, either free-running or single-stepped.
//
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   start, abort          begin load+run (IDLE/DONE only); return to IDLE
//   run_len, step_mode    run length (0 = 2**CNT_W) and step select, latched on start
//   step                  one instruction per high cycle in single-step RUN
//   prog_valid/prog_data  program word stream; prog_ready is its handshake
//   imem_we/waddr/wdata   instruction memory write port
//   core_clr, core_en     core clear pulse and advance enable
//   busy, done            LOAD/CLEAR/RUN and DONE status
//   exec_count            instructions executed since CLEAR (wrapping)
module cpu_run_ctrl #(
  parameter int unsigned ADDR_W  = 2,
  parameter int unsigned INSTR_W = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   run_len,
  input  logic               step_mode,
  input  logic               step,
  input  logic               prog_valid,
  input  logic [INSTR_W-1:0] prog_data,
  output logic               prog_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_waddr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               core_clr,
  output logic               core_en,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   exec_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CLEAR = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  load_ptr;
  logic [CNT_W-1:0]   exec_cnt_q;
  logic [CNT_W-1:0]   run_len_q;
  logic               step_mode_q;

  logic               in_load;
  logic               run_fire;
  logic               last_word;
  logic               last_exec;

  // Advance request in RUN before abort gating; step is only honoured in step mode.
  assign in_load   = (state == S_LOAD);
  assign run_fire  = (state == S_RUN) && (step_mode_q ? step : 1'b1);
  assign last_word = (load_ptr == ADDR_W'(DEPTH - 1));
  // run_len_q = 0 wraps to all-ones, i.e. a target of 2**CNT_W executions.
  assign last_exec = (exec_cnt_q == CNT_W'(run_len_q - CNT_W'(1)));

  // Sequencer state, load pointer, execute counter and start-time latches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      load_ptr    <= '0;
      exec_cnt_q  <= '0;
      run_len_q   <= '0;
      step_mode_q <= 1'b0;
    end else if (abort) begin
      state      <= S_IDLE;
      load_ptr   <= '0;
      exec_cnt_q <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_LOAD;
            run_len_q   <= run_len;
            step_mode_q <= step_mode;
            load_ptr    <= '0;
          end
        end
        S_LOAD: begin
          if (prog_valid) begin
            load_ptr <= ADDR_W'(load_ptr + ADDR_W'(1));
            if (last_word) state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          exec_cnt_q <= '0;
          state      <= S_RUN;
        end
        S_RUN: begin
          if (run_fire) begin
            exec_cnt_q <= CNT_W'(exec_cnt_q + CNT_W'(1));
            if (last_exec) state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake and core enable are killed by abort in the same cycle.
  assign prog_ready = in_load && !abort;
  assign imem_we    = in_load && prog_valid && !abort;
  assign imem_waddr = load_ptr;
  assign imem_wdata = in_load ? prog_data : '0;
  assign core_en    = run_fire && !abort;

  // Status decoded from the state register.
  assign core_clr   = (state == S_CLEAR);
  assign busy       = (state == S_LOAD) || (state == S_CLEAR) || (state == S_RUN);
  assign done       = (state == S_DONE);
  assign exec_count = exec_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
`timescale 1ns/1ps
module tb_cpu_run_ctrl;

  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned INSTR_W = 2;
  localparam int unsigned CNT_W   = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               abort;
  logic [CNT_W-1:0]   run_len;
  logic               step_mode;
  logic               step;
  logic               prog_valid;
  logic [INSTR_W-1:0] prog_data;
  logic               prog_ready;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_waddr;
  logic [INSTR_W-1:0] imem_wdata;
  logic               core_clr;
  logic               core_en;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   exec_count;

  cpu_run_ctrl #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .run_len(run_len),
    .step_mode(step_mode), .step(step), .prog_valid(prog_valid), .prog_data(prog_data),
    .prog_ready(prog_ready), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .core_clr(core_clr), .core_en(core_en), .busy(busy),
    .done(done), .exec_count(exec_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Recorded by the stimulus helpers, judged by the test tasks.
  logic [1:0]  wr_addr[$];
  logic [1:0]  wr_data[$];
  bit          clr_in_load;
  int          load_cycles;
  logic [63:0] en_pat;
  logic [3:0]  ec_tr [0:64];
  int          done_k;

  // Inputs change at negedge+1; outputs are observed 1ns later, well before posedge.
  task automatic step_clk();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] rl, input bit sm);
    start = 1'b1; run_len = rl; step_mode = sm;
    step_clk();
    start = 1'b0; run_len = 4'($urandom); step_mode = 1'($urandom);
  endtask

  // mode 0: valid always, 1: valid toggles 1,0,1,..., 2: random valid.
  task automatic do_load(input logic [1:0] words [4], input int mode);
    int idx; bit v; bit tog;
    wr_addr.delete(); wr_data.delete();
    clr_in_load = 1'b0; load_cycles = 0; idx = 0; tog = 1'b1;
    while (idx < 4 && load_cycles < 200) begin
      case (mode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = ~tog; end
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      prog_valid = v;
      prog_data  = v ? words[idx] : 2'($urandom);
      #1;
      if (imem_we) begin wr_addr.push_back(imem_waddr); wr_data.push_back(imem_wdata); end
      if (core_clr) clr_in_load = 1'b1;
      if (v) idx++;
      step_clk();
      load_cycles++;
    end
    prog_valid = 1'b0; prog_data = '0;
  endtask

  // Starts on the first RUN cycle; stops at the first cycle showing done.
  task automatic do_run(input logic [63:0] sp, input int max);
    en_pat = '0; done_k = -1;
    for (int k = 0; k < max; k++) begin
      step = sp[k];
      #1;
      ec_tr[k] = exec_count;
      if (done) begin done_k = k; break; end
      en_pat[k] = core_en;
      step_clk();
    end
    step = 1'b0;
  endtask

  // Reference: count enables from the rules, report the cycle at which done shows.
  function automatic int exp_run(input logic [63:0] sp, input bit sm, input int t,
                                 output logic [63:0] ep);
    int cnt; cnt = 0; ep = '0;
    for (int k = 0; k < 64; k++) begin
      if (cnt == t) return k;
      if (!sm || sp[k]) begin ep[k] = 1'b1; cnt++; end
    end
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 0; abort = 0; run_len = 0; step_mode = 0; step = 0;
    prog_valid = 0; prog_data = 0;
    #1;
    n_checks++;
    if ({prog_ready, imem_we, imem_waddr, imem_wdata, core_clr, core_en, busy, done, exec_count} !== 14'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 0",
        {prog_ready, imem_we, imem_waddr, imem_wdata, core_clr, core_en, busy, done, exec_count});
    end
    step_clk(); step_clk();
    reset = 1'b0;
    step_clk();
    n_checks++;
    if ({busy, done, prog_ready, core_clr, exec_count} !== 8'd0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b want 0", {busy, done, prog_ready, core_clr, exec_count});
    end
  endtask

  task automatic test_free_run();
    logic [1:0] w [4];
    w = '{2'b01, 2'b11, 2'b00, 2'b00};
    do_start(4'd2, 1'b0);
    n_checks++;
    if (prog_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL load_entry: ready=%b busy=%b want 1 1", prog_ready, busy);
    end
    do_load(w, 0);
    n_checks++;
    if (wr_addr.size() != 4 || load_cycles != 4) begin
      n_fail++; $display("FAIL free_write_count: writes=%0d cycles=%0d want 4 4", wr_addr.size(), load_cycles);
    end
    for (int i = 0; i < wr_addr.size() && i < 4; i++) begin
      n_checks++;
      if (wr_addr[i] !== 2'(i) || wr_data[i] !== w[i]) begin
        n_fail++; $display("FAIL free_write[%0d]: addr=%0d data=%b want %0d %b", i, wr_addr[i], wr_data[i], i, w[i]);
      end
    end
    n_checks++;
    if ({core_clr, core_en, busy} !== 3'b101) begin
      n_fail++; $display("FAIL free_clear: clr/en/busy=%b want 101", {core_clr, core_en, busy});
    end
    step_clk();
    do_run({$urandom, $urandom}, 64);
    n_checks++;
    if (done_k != 2 || en_pat !== 64'h3) begin
      n_fail++; $display("FAIL free_run: done_k=%0d en=%h want 2 3", done_k, en_pat);
    end
    n_checks++;
    if (done_k >= 0 && (ec_tr[done_k] !== 4'd2 || busy !== 1'b0)) begin
      n_fail++; $display("FAIL free_done: exec=%0d busy=%b want 2 0", ec_tr[done_k], busy);
    end
    step_clk(); step_clk();
    n_checks++;
    if (done !== 1'b1 || exec_count !== 4'd2 || core_en !== 1'b0) begin
      n_fail++; $display("FAIL done_hold: done=%b exec=%0d en=%b want 1 2 0", done, exec_count, core_en);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = 2'($urandom);
    do_start(4'd5, 1'b0);
    do_load(w, 1);
    n_checks++;
    if (wr_addr.size() != 4 || load_cycles != 7 || clr_in_load) begin
      n_fail++; $display("FAIL bp_writes: writes=%0d cycles=%0d early_clr=%b want 4 7 0",
        wr_addr.size(), load_cycles, clr_in_load);
    end
    for (int i = 0; i < wr_addr.size() && i < 4; i++) begin
      n_checks++;
      if (wr_addr[i] !== 2'(i) || wr_data[i] !== w[i]) begin
        n_fail++; $display("FAIL bp_write[%0d]: addr=%0d data=%b want %0d %b", i, wr_addr[i], wr_data[i], i, w[i]);
      end
    end
    n_checks++;
    if (core_clr !== 1'b1) begin n_fail++; $display("FAIL bp_clear: clr=%b want 1", core_clr); end
    step_clk();
    do_run('0, 64);
    n_checks++;
    if (done_k != 5 || en_pat !== 64'h1F) begin
      n_fail++; $display("FAIL bp_run: done_k=%0d en=%h want 5 1f", done_k, en_pat);
    end
  endtask

  task automatic test_step_mode();
    logic [1:0] w [4]; logic [63:0] sp; logic [63:0] ep; int ek; int cnt;
    for (int i = 0; i < 4; i++) w[i] = 2'($urandom);
    do_start(4'd3, 1'b1);
    do_load(w, 2);
    n_checks++;
    if (core_clr !== 1'b1 || core_en !== 1'b0) begin
      n_fail++; $display("FAIL step_clear: clr=%b en=%b want 1 0", core_clr, core_en);
    end
    step_clk();
    sp = '0; sp[5] = 1'b1; sp[9] = 1'b1; sp[10] = 1'b1;
    do_run(sp, 64);
    ek = exp_run(sp, 1'b1, 3, ep);
    n_checks++;
    if (done_k != ek || en_pat !== ep) begin
      n_fail++; $display("FAIL step_run: done_k=%0d en=%h want %0d %h", done_k, en_pat, ek, ep);
    end
    cnt = 0;
    for (int k = 0; k <= ek && k <= done_k; k++) begin
      n_checks++;
      if (ec_tr[k] !== 4'(cnt)) begin
        n_fail++; $display("FAIL step_exec[%0d]: got %0d want %0d", k, ec_tr[k], cnt);
      end
      if (ep[k]) cnt++;
    end
  endtask

  task automatic test_run_len_zero();
    logic [1:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = 2'($urandom);
    do_start(4'd0, 1'b0);
    do_load(w, 0);
    step_clk();
    do_run('0, 64);
    n_checks++;
    if (done_k != 16 || en_pat !== 64'hFFFF) begin
      n_fail++; $display("FAIL rl0_run: done_k=%0d en=%h want 16 ffff", done_k, en_pat);
    end
    n_checks++;
    if (done_k >= 0 && ec_tr[done_k] !== 4'd0) begin
      n_fail++; $display("FAIL rl0_exec: got %0d want 0", ec_tr[done_k]);
    end
  endtask

  task automatic test_abort_run();
    logic [1:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = 2'($urandom);
    do_start(4'd6, 1'b1);
    do_load(w, 0);
    step_clk();
    step = 1'b1; step_clk();
    step = 1'b0; step_clk();
    abort = 1'b1; step = 1'b1; prog_valid = 1'b1; start = 1'b1;
    #1;
    n_checks++;
    if ({core_en, imem_we, prog_ready} !== 3'b000) begin
      n_fail++; $display("FAIL abort_run_cycle: en/we/ready=%b want 000", {core_en, imem_we, prog_ready});
    end
    step_clk();
    abort = 1'b0; step = 1'b0; start = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, core_clr, imem_we, exec_count} !== 8'd0) begin
      n_fail++; $display("FAIL abort_run_idle: busy/done/clr/we/exec=%b want 0",
        {busy, done, core_clr, imem_we, exec_count});
    end
    prog_valid = 1'b0;
    step_clk();
  endtask

  task automatic test_abort_load();
    logic [1:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = 2'($urandom);
    do_start(4'd2, 1'b0);
    prog_valid = 1'b1; prog_data = 2'b10;
    step_clk();
    abort = 1'b1;
    #1;
    n_checks++;
    if (imem_we !== 1'b0 || prog_ready !== 1'b0) begin
      n_fail++; $display("FAIL abort_load_cycle: we=%b ready=%b want 0 0", imem_we, prog_ready);
    end
    step_clk();
    abort = 1'b0; prog_valid = 1'b0;
    #1;
    n_checks++;
    if ({busy, prog_ready, imem_waddr, imem_wdata} !== 6'd0) begin
      n_fail++; $display("FAIL abort_load_idle: busy/ready/addr/data=%b want 0",
        {busy, prog_ready, imem_waddr, imem_wdata});
    end
    step_clk();
    do_start(4'd2, 1'b0);
    do_load(w, 0);
    n_checks++;
    if (wr_addr.size() != 4 || wr_addr[0] !== 2'd0 || core_clr !== 1'b1) begin
      n_fail++; $display("FAIL abort_reload: writes=%0d first=%0d clr=%b want 4 0 1",
        wr_addr.size(), wr_addr[0], core_clr);
    end
    step_clk();
    do_run('0, 64);
  endtask

  task automatic test_async_reset();
    logic [1:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = 2'($urandom);
    do_start(4'd10, 1'b0);
    do_load(w, 0);
    step_clk(); step_clk(); step_clk(); step_clk();
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({prog_ready, imem_we, core_clr, core_en, busy, done, exec_count} !== 10'd0) begin
      n_fail++; $display("FAIL async_reset: outputs=%b want 0",
        {prog_ready, imem_we, core_clr, core_en, busy, done, exec_count});
    end
    step_clk();
    reset = 1'b0;
    step_clk();
  endtask

  task automatic test_start_while_busy();
    logic [1:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = 2'($urandom);
    do_start(4'd3, 1'b0);
    do_load(w, 0);
    start = 1'b1; run_len = 4'd7; step_mode = 1'b0;
    step_clk();
    do_run('0, 64);
    n_checks++;
    if (done_k != 3 || en_pat !== 64'h7) begin
      n_fail++; $display("FAIL busy_start_run: done_k=%0d en=%h want 3 7", done_k, en_pat);
    end
    step_clk();
    start = 1'b0;
    #1;
    n_checks++;
    if (prog_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL done_restart: ready=%b busy=%b done=%b want 1 1 0", prog_ready, busy, done);
    end
    do_load(w, 0);
    step_clk();
    do_run('0, 64);
    n_checks++;
    if (done_k != 7 || (done_k >= 0 && ec_tr[done_k] !== 4'd7)) begin
      n_fail++; $display("FAIL restart_run: done_k=%0d want 7", done_k);
    end
  endtask

  task automatic test_random();
    logic [1:0] w [4]; logic [63:0] sp; logic [63:0] ep; int ek; int t;
    logic [3:0] rl; bit sm;
    for (int it = 0; it < 10; it++) begin
      rl = 4'($urandom_range(0, 15)); sm = 1'($urandom_range(0, 1));
      t = (rl == 0) ? 16 : int'(rl);
      for (int i = 0; i < 4; i++) w[i] = 2'($urandom);
      for (int k = 0; k < 64; k++) sp[k] = ($urandom_range(0, 3) != 0);
      do_start(rl, sm);
      do_load(w, $urandom_range(0, 2));
      n_checks++;
      if (wr_addr.size() != 4 || clr_in_load || core_clr !== 1'b1) begin
        n_fail++; $display("FAIL rnd_load[%0d]: writes=%0d early=%b clr=%b want 4 0 1",
          it, wr_addr.size(), clr_in_load, core_clr);
      end
      for (int i = 0; i < wr_addr.size() && i < 4; i++) begin
        n_checks++;
        if (wr_addr[i] !== 2'(i) || wr_data[i] !== w[i]) begin
          n_fail++; $display("FAIL rnd_write[%0d.%0d]: addr=%0d data=%b want %0d %b",
            it, i, wr_addr[i], wr_data[i], i, w[i]);
        end
      end
      step_clk();
      do_run(sp, 64);
      ek = exp_run(sp, sm, t, ep);
      n_checks++;
      if (done_k != ek || en_pat !== ep) begin
        n_fail++; $display("FAIL rnd_run[%0d]: rl=%0d sm=%b done_k=%0d en=%h want %0d %h",
          it, rl, sm, done_k, en_pat, ek, ep);
      end
      if (ek >= 0 && done_k == ek) begin
        n_checks++;
        if (ec_tr[done_k] !== 4'(t)) begin
          n_fail++; $display("FAIL rnd_exec[%0d]: got %0d want %0d", it, ec_tr[done_k], 4'(t));
        end
      end
      abort = 1'b1; step_clk(); abort = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_fail++; $display("FAIL rnd_abort[%0d]: busy=%b done=%b want 0 0", it, busy, done);
      end
      step_clk();
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_backpressure();
    test_step_mode();
    test_run_len_zero();
    test_abort_run();
    test_abort_load();
    test_async_reset();
    test_start_while_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
